// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one radix-4 Booth multiplier among NREQ requesters; MULT_ARB_TIMEOUT_EN adds a WAIT watchdog.
// Latency: req_ready in grant cycle 0, mul_start in cycle 1, rsp_valid/mul_ack one cycle after mul_irq; all outputs registered.
// Backpressure: one transaction in flight; other requesters hold req_valid until their one-cycle req_ready pulse.
module mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  output logic [2:0]           rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 mul_start,
  output logic                 mul_ack,
  output logic                 mul_irq_enable,
  output logic [15:0]          mul_data_a,
  output logic [15:0]          mul_data_b,
  input  logic                 mul_busy,
  input  logic                 mul_irq,
  input  logic [31:0]          mul_result
);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("mult_arbiter: NREQ must be 2..8 and TIMEOUT 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        gnt_q, gnt_d;

  logic              hi_vld, lo_vld, pick_vld;
  logic [2:0]        hi_idx, lo_idx, pick;
  logic [NREQ-1:0]   pick_oh;
  logic [15:0]       sel_a, sel_b;

  logic [NREQ-1:0]   req_ready_d;
  logic              rsp_valid_d;
  logic [2:0]        rsp_id_d;
  logic [31:0]       rsp_result_d;
  logic              busy_d;
  logic              start_d;
  logic              ack_d;
  logic [15:0]       a_d, b_d;

`ifdef MULT_ARB_TIMEOUT_EN
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Round-robin pick: lowest set index at or above the pointer, else lowest below it.
  always_comb begin
    hi_vld = 1'b0;
    lo_vld = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (3'(i) >= ptr_q) begin
          hi_vld = 1'b1;
          hi_idx = 3'(i);
        end else begin
          lo_vld = 1'b1;
          lo_idx = 3'(i);
        end
      end
    end
    pick_vld = hi_vld | lo_vld;
    pick     = hi_vld ? hi_idx : lo_idx;

    pick_oh = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (3'(i) == pick) begin
        pick_oh[i] = 1'b1;
        sel_a      = req_a[16*i +: 16];
        sel_b      = req_b[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    req_ready_d  = '0;
    rsp_valid_d  = 1'b0;
    rsp_id_d     = rsp_id;
    rsp_result_d = rsp_result;
    busy_d       = busy;
    start_d      = 1'b0;
    ack_d        = mul_ack;
    a_d          = mul_data_a;
    b_d          = mul_data_b;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          req_ready_d = pick_oh;
          a_d         = sel_a;
          b_d         = sel_b;
          gnt_d       = pick;
          ptr_d       = (pick == 3'(NREQ - 1)) ? 3'd0 : pick + 3'd1;
          busy_d      = 1'b1;
          state_d     = S_START;
        end
      end

      S_START: begin
        start_d = 1'b1;
        state_d = S_WAIT;
`ifdef MULT_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end

      S_WAIT: begin
        // irq is tested first so a product arriving on the watchdog's last cycle still wins
        if (mul_irq) begin
          rsp_result_d = mul_result;
          rsp_id_d     = gnt_q;
          rsp_valid_d  = 1'b1;
          ack_d        = 1'b1;
          state_d      = S_ACK;
`ifdef MULT_ARB_TIMEOUT_EN
          err_d        = 1'b0;
`endif
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          rsp_result_d = '0;
          rsp_id_d     = gnt_q;
          rsp_valid_d  = 1'b1;
          ack_d        = 1'b1;
          err_d        = 1'b1;
          state_d      = S_ACK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end

      S_ACK: begin
        if (!mul_busy) begin
          ack_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      gnt_q          <= '0;
      req_ready      <= '0;
      rsp_valid      <= 1'b0;
      rsp_id         <= '0;
      rsp_result     <= '0;
      busy           <= 1'b0;
      mul_start      <= 1'b0;
      mul_ack        <= 1'b0;
      mul_irq_enable <= 1'b0;
      mul_data_a     <= '0;
      mul_data_b     <= '0;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q          <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gnt_q          <= gnt_d;
      req_ready      <= req_ready_d;
      rsp_valid      <= rsp_valid_d;
      rsp_id         <= rsp_id_d;
      rsp_result     <= rsp_result_d;
      busy           <= busy_d;
      mul_start      <= start_d;
      mul_ack        <= ack_d;
      mul_irq_enable <= 1'b1;
      mul_data_a     <= a_d;
      mul_data_b     <= b_d;
`ifdef MULT_ARB_TIMEOUT_EN
      cnt_q          <= cnt_d;
      err_q          <= err_d;
`endif
    end
  end

endmodule
